// File: rtl/noc_ni_pkg.sv
// Shared definitions for the core-side network interface.
// Holds the mesh packet geometry, the FIFO entry layout and the helpers that
// convert between the serial-order packet vector ([0] = valid, MSB-first) and
// its fields. Also holds the saturating increment used by the statistics
// counters.
package noc_ni_pkg;

    localparam int unsigned PKT_LEN = 16;
    localparam int unsigned COORD_W = 2;
    localparam int unsigned PAY_W   = PKT_LEN - 1 - 4 * COORD_W;

    // Field offsets within the MSB-first packet vector.
    localparam int unsigned OFF_VALID = 0;
    localparam int unsigned OFF_DST_Y = 1;
    localparam int unsigned OFF_DST_X = OFF_DST_Y + COORD_W;
    localparam int unsigned OFF_SRC_Y = OFF_DST_X + COORD_W;
    localparam int unsigned OFF_SRC_X = OFF_SRC_Y + COORD_W;
    localparam int unsigned OFF_PAY   = OFF_SRC_X + COORD_W;

    typedef logic [0:PKT_LEN-1] pkt_t;

    // FIFO entry: a coordinate pair (dst on TX, src on RX) plus payload.
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic [PAY_W-1:0]   payload;
    } entry_t;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] dst_y;
        logic [COORD_W-1:0] dst_x;
        logic [COORD_W-1:0] src_y;
        logic [COORD_W-1:0] src_x;
        logic [PAY_W-1:0]   payload;
    } fields_t;

    function automatic pkt_t pack_pkt(input logic [COORD_W-1:0] dst_y,
                                      input logic [COORD_W-1:0] dst_x,
                                      input logic [COORD_W-1:0] src_y,
                                      input logic [COORD_W-1:0] src_x,
                                      input logic [PAY_W-1:0]   payload);
        return {1'b1, dst_y, dst_x, src_y, src_x, payload};
    endfunction

    function automatic fields_t unpack_pkt(input pkt_t p);
        fields_t f;
        f.valid   = p[OFF_VALID];
        f.dst_y   = p[OFF_DST_Y +: COORD_W];
        f.dst_x   = p[OFF_DST_X +: COORD_W];
        f.src_y   = p[OFF_SRC_Y +: COORD_W];
        f.src_x   = p[OFF_SRC_X +: COORD_W];
        f.payload = p[OFF_PAY +: PAY_W];
        return f;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, push_data    write request and data (accepted when not full, or when
//                      a pop happens on the same edge)
//   pop                read request (ignored when empty)
//   pop_data           current head, valid whenever empty=0
//   empty              registered empty flag
//   full_next          occupancy after the coming edge equals DEPTH (comb)
module noc_ni_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full_next
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_pop  = pop & ~empty_q;
    // A full FIFO may still take a write when the head leaves on the same edge.
    assign do_push = push & (~full_q | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign full_next = (cnt_d == FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= full_next;
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = empty_q;

endmodule

// File: rtl/noc_core_ni.sv
// Core-side network interface for one mesh node.
// TX: core requests (dst + payload) queue in a FIFO; a registered output stage
//     stamps src = own node and valid = 1 and holds the packet on noc_out until
//     the router takes it (noc_out_ready).
// RX: valid packets from the router are accepted while noc_in_ready; those
//     addressed to this node are queued for the core, others are dropped.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   node_y, node_x                 own coordinates
//   tx_valid/ready, tx_dst_y/x, tx_payload     core send channel
//   rx_valid/ready, rx_src_y/x, rx_payload     core receive channel
//   noc_out, noc_out_ready         packet to router and its ready
//   noc_in, noc_in_ready           packet from router and our ready
//   tx_count, rx_count, drop_count saturating statistics
module noc_core_ni
    import noc_ni_pkg::*;
#(
    parameter int unsigned PL       = PKT_LEN,
    parameter int unsigned CW       = COORD_W,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CW-1:0]         node_y,
    input  logic [CW-1:0]         node_x,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [CW-1:0]         tx_dst_y,
    input  logic [CW-1:0]         tx_dst_x,
    input  logic [PL-1-4*CW-1:0]  tx_payload,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [CW-1:0]         rx_src_y,
    output logic [CW-1:0]         rx_src_x,
    output logic [PL-1-4*CW-1:0]  rx_payload,
    output logic [0:PL-1]         noc_out,
    input  logic                  noc_out_ready,
    input  logic [0:PL-1]         noc_in,
    output logic                  noc_in_ready,
    output logic [15:0]           tx_count,
    output logic [15:0]           rx_count,
    output logic [15:0]           drop_count
);

    entry_t      tx_wdata, tx_head, rx_wdata, rx_head;
    logic        tx_push, tx_pop, tx_empty, tx_full_next;
    logic        rx_push, rx_pop, rx_empty, rx_full_next;
    logic        tx_ready_q, noc_in_ready_q;
    pkt_t        out_q;
    logic        retire;
    fields_t     in_f;
    logic        capture, dst_hit;
    logic [15:0] tx_cnt_q, rx_cnt_q, drop_cnt_q;

    // ---------------- TX path ----------------
    assign tx_push  = tx_valid & tx_ready_q;
    assign tx_wdata = '{y: tx_dst_y, x: tx_dst_x, payload: tx_payload};
    assign retire   = out_q[OFF_VALID] & noc_out_ready;
    // Refill the stage when it is empty or its packet leaves on this edge.
    assign tx_pop   = ~tx_empty & (~out_q[OFF_VALID] | noc_out_ready);

    noc_ni_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (tx_wdata),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .empty     (tx_empty),
        .full_next (tx_full_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (tx_pop) begin
            out_q <= pack_pkt(tx_head.y, tx_head.x, node_y, node_x, tx_head.payload);
        end else if (retire) begin
            out_q <= '0;
        end
    end

    // ---------------- RX path ----------------
    assign in_f     = unpack_pkt(noc_in);
    assign capture  = in_f.valid & noc_in_ready_q;
    assign dst_hit  = (in_f.dst_y == node_y) && (in_f.dst_x == node_x);
    assign rx_push  = capture & dst_hit;
    assign rx_wdata = '{y: in_f.src_y, x: in_f.src_x, payload: in_f.payload};
    assign rx_pop   = rx_ready & ~rx_empty;

    noc_ni_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_wdata),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .empty     (rx_empty),
        .full_next (rx_full_next)
    );

    // Readies are held low in reset and track next-edge occupancy afterwards,
    // so neither depends combinationally on the incoming request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready_q     <= 1'b0;
            noc_in_ready_q <= 1'b0;
        end else begin
            tx_ready_q     <= ~tx_full_next;
            noc_in_ready_q <= ~rx_full_next;
        end
    end

    // ---------------- Statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (retire)              tx_cnt_q   <= sat_inc(tx_cnt_q);
            if (rx_push)             rx_cnt_q   <= sat_inc(rx_cnt_q);
            if (capture && !dst_hit) drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign tx_ready     = tx_ready_q;
    assign noc_in_ready = noc_in_ready_q;
    assign noc_out      = out_q;
    assign rx_valid     = ~rx_empty;
    assign rx_src_y     = rx_head.y;
    assign rx_src_x     = rx_head.x;
    assign rx_payload   = rx_head.payload;
    assign tx_count     = tx_cnt_q;
    assign rx_count     = rx_cnt_q;
    assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_noc_core_ni.sv
// Testbench for noc_core_ni: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based behavioural model of the NI.
module tb_noc_core_ni;

    localparam int PL  = 16;
    localparam int CW  = 2;
    localparam int PW  = 7;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int NY  = 1;
    localparam int NX  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [CW-1:0]   node_y = 2'(NY);
    logic [CW-1:0]   node_x = 2'(NX);
    logic            tx_valid = 1'b0;
    logic            tx_ready;
    logic [CW-1:0]   tx_dst_y = '0;
    logic [CW-1:0]   tx_dst_x = '0;
    logic [PW-1:0]   tx_payload = '0;
    logic            rx_valid;
    logic            rx_ready = 1'b0;
    logic [CW-1:0]   rx_src_y, rx_src_x;
    logic [PW-1:0]   rx_payload;
    logic [0:PL-1]   noc_out;
    logic            noc_out_ready = 1'b0;
    logic [0:PL-1]   noc_in = '0;
    logic            noc_in_ready;
    logic [15:0]     tx_count, rx_count, drop_count;

    noc_core_ni #(
        .PL       (PL),
        .CW       (CW),
        .TX_DEPTH (TXD),
        .RX_DEPTH (RXD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .node_y        (node_y),
        .node_x        (node_x),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_dst_y      (tx_dst_y),
        .tx_dst_x      (tx_dst_x),
        .tx_payload    (tx_payload),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_src_y      (rx_src_y),
        .rx_src_x      (rx_src_x),
        .rx_payload    (rx_payload),
        .noc_out       (noc_out),
        .noc_out_ready (noc_out_ready),
        .noc_in        (noc_in),
        .noc_in_ready  (noc_in_ready),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packet as a number: valid is the top bit, then dst_y, dst_x, src_y, src_x, payload.
    function automatic logic [15:0] mk_pkt(input int dy, input int dx, input int sy,
                                           input int sx, input int pl);
        return 16'((1 << 15) + (dy << 13) + (dx << 11) + (sy << 9) + (sx << 7) + pl);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] pkt;
        int          rdy;   // first edge at which it may appear on noc_out
    } txe_t;
    typedef struct {
        int y;
        int x;
        int pl;
    } rxe_t;

    txe_t txq[$];           // accepted, not yet taken by the router (head may be on noc_out)
    rxe_t rxq[$];           // accepted for this node, not yet consumed by the core
    int   cyc = 0;
    int   m_tx = 0, m_rx = 0, m_drop = 0;
    bit   e_tx_rdy = 0, e_in_rdy = 0, e_out_vis = 0;
    bit   tx_acc = 0, in_acc = 0;

    // Router-side pending inbound packet.
    bit in_pend = 0;
    int in_dy, in_dx, in_sy, in_sx, in_pl;

    task automatic set_in();
        noc_in = in_pend ? mk_pkt(in_dy, in_dx, in_sy, in_sx, in_pl) : '0;
    endtask

    task automatic new_in(input bit to_self);
        in_pend = 1;
        in_dy = to_self ? NY : int'($urandom_range(0, 3));
        in_dx = to_self ? NX : int'($urandom_range(0, 3));
        in_sy = int'($urandom_range(0, 3));
        in_sx = int'($urandom_range(0, 3));
        in_pl = int'($urandom_range(0, 127));
        set_in();
    endtask

    task automatic new_tx();
        tx_valid   = 1'b1;
        tx_dst_y   = 2'($urandom_range(0, 3));
        tx_dst_x   = 2'($urandom_range(0, 3));
        tx_payload = 7'($urandom_range(0, 127));
    endtask

    function automatic void sat(inout int c);
        if (c < 65535) c++;
    endfunction

    // One clock edge: decide handshakes from the model's own view of the
    // readies, advance the model, then compare every output.
    task automatic tick();
        bit acc_t, acc_i, pop_r, ret;
        int occ;
        acc_t = tx_valid && e_tx_rdy;
        acc_i = in_pend && e_in_rdy;
        pop_r = (rxq.size() > 0) && rx_ready;
        ret   = e_out_vis && noc_out_ready;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ret) begin
            void'(txq.pop_front());
            sat(m_tx);
        end
        if (acc_t) txq.push_back('{pkt: mk_pkt(tx_dst_y, tx_dst_x, NY, NX, tx_payload),
                                   rdy: cyc + 1});
        if (pop_r) void'(rxq.pop_front());
        if (acc_i) begin
            if (in_dy == NY && in_dx == NX) begin
                rxq.push_back('{y: in_sy, x: in_sx, pl: in_pl});
                sat(m_rx);
            end else begin
                sat(m_drop);
            end
        end
        tx_acc    = acc_t;
        in_acc    = acc_i;
        e_out_vis = (txq.size() > 0) && (txq[0].rdy <= cyc);
        occ       = txq.size() - (e_out_vis ? 1 : 0);
        e_tx_rdy  = occ < TXD;
        e_in_rdy  = rxq.size() < RXD;

        if (e_out_vis) check("noc_out", noc_out, txq[0].pkt);
        else           check("noc_out_idle", noc_out, 0);
        check("tx_ready", tx_ready, e_tx_rdy);
        check("noc_in_ready", noc_in_ready, e_in_rdy);
        check("rx_valid", rx_valid, rxq.size() > 0);
        if (rxq.size() > 0) begin
            check("rx_src_y", rx_src_y, rxq[0].y);
            check("rx_src_x", rx_src_x, rxq[0].x);
            check("rx_payload", rx_payload, rxq[0].pl);
        end
        check("tx_count", tx_count, m_tx);
        check("rx_count", rx_count, m_rx);
        check("drop_count", drop_count, m_drop);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic do_reset();
        tx_valid = 1'b0;
        in_pend  = 0;
        set_in();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_noc_out", noc_out, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_noc_in_ready", noc_in_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_count", tx_count, 0);
        txq.delete();
        rxq.delete();
        m_tx = 0; m_rx = 0; m_drop = 0;
        e_tx_rdy = 0; e_in_rdy = 0; e_out_vis = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_tx_ready_low", tx_ready, 0);
        check("rel_noc_in_ready_low", noc_in_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, n;

        // 1. Reset and release
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_noc_out", noc_out, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_tx_ready", tx_ready, 0);
        check("reset_noc_in_ready", noc_in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("release_tx_ready_low", tx_ready, 0);
        check("release_noc_in_ready_low", noc_in_ready, 0);
        tick();
        check("first_edge_tx_ready", tx_ready, 1);
        check("first_edge_noc_in_ready", noc_in_ready, 1);

        // 2. Single send dst=(3,0) payload 0x5A from node (1,2)
        noc_out_ready = 1'b1;
        tx_valid = 1'b1; tx_dst_y = 2'd3; tx_dst_x = 2'd0; tx_payload = 7'h5A;
        tick();
        tx_valid = 1'b0;
        check("t2_stage_not_yet", noc_out, 0);
        tick();
        check("t2_packet", noc_out, 32'hE35A);
        tick();
        check("t2_tx_count", tx_count, 1);
        check("t2_after_retire", noc_out, 0);

        // 3. Router back-pressure for 10 cycles with 6 requests
        noc_out_ready = 1'b0;
        acc = 0;
        new_tx();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_acc) begin
                acc++;
                if (acc < 6) new_tx(); else tx_valid = 1'b0;
            end
        end
        check("t3_tx_ready_full", tx_ready, 0);
        check("t3_held_count", tx_count, 1);
        noc_out_ready = 1'b1;
        n = 0;
        while ((acc < 6 || txq.size() > 0) && n < 20) begin
            tick();
            n++;
            if (tx_acc) begin
                acc++;
                if (acc < 6) new_tx(); else tx_valid = 1'b0;
            end
            if (txq.size() > 0) check("t3_back_to_back", noc_out[0], 1);
        end
        check("t3_drained", txq.size(), 0);
        check("t3_tx_count", tx_count, 7);

        // 4. Five packets for this node while the core is not consuming
        rx_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (!in_pend && acc < 5) new_in(1);
            tick();
            if (in_acc) begin acc++; in_pend = 0; set_in(); end
        end
        check("t4_noc_in_ready_full", noc_in_ready, 0);
        check("t4_rx_count_full", rx_count, 4);
        check("t4_fifth_pending", noc_in[0], 1);
        rx_ready = 1'b1;
        n = 0;
        while ((acc < 5 || rxq.size() > 0) && n < 20) begin
            if (!in_pend && acc < 5) new_in(1);
            tick();
            n++;
            if (in_acc) begin acc++; in_pend = 0; set_in(); end
        end
        check("t4_drained", rxq.size(), 0);
        check("t4_rx_count", rx_count, 5);

        // 5. Packet for another node is dropped
        in_pend = 1; in_dy = 0; in_dx = 0; in_sy = 3; in_sx = 3; in_pl = 7'h11;
        set_in();
        tick();
        in_pend = 0; set_in();
        tick();
        check("t5_rx_valid", rx_valid, 0);
        check("t5_drop_count", drop_count, 1);
        check("t5_rx_count", rx_count, 5);

        // Randomized traffic in both directions
        for (int i = 0; i < 300; i++) begin
            if (!tx_valid && $urandom_range(0, 1) == 1) new_tx();
            if (!in_pend && $urandom_range(0, 1) == 1) new_in($urandom_range(0, 2) != 0);
            noc_out_ready = $urandom_range(0, 3) != 0;
            rx_ready      = $urandom_range(0, 2) != 0;
            tick();
            if (tx_acc) tx_valid = 1'b0;
            if (in_acc) begin in_pend = 0; set_in(); end
        end
        tx_valid = 1'b0; in_pend = 0; set_in();
        noc_out_ready = 1'b1; rx_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // 6. Reset while three packets are queued behind a stalled router
        noc_out_ready = 1'b0;
        acc = 0;
        new_tx();
        n = 0;
        while (acc < 3 && n < 10) begin
            tick();
            n++;
            if (tx_acc) begin
                acc++;
                if (acc < 3) new_tx(); else tx_valid = 1'b0;
            end
        end
        check("t6_queued", acc, 3);
        do_reset();
        noc_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("t6_nothing_sent", tx_count, 0);
        check("t6_noc_out_idle", noc_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
